// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI receiver slice.
//   spi_state_e            : receiver FSM states (IDLE, RECV)
//   SPI_DEFAULT_DATA_WIDTH : default bits per received word
//   SPI_DEFAULT_CS_POLAR   : default idle level of cs_n (active level is inverse)
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } spi_state_e;

  localparam int SPI_DEFAULT_DATA_WIDTH = 8;
  localparam int SPI_DEFAULT_CS_POLAR   = 1;

endpackage

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync
// Two-flop synchronizer bringing an asynchronous input into the clk domain.
// Both flops take P_RESET_VAL on either reset so the synchronized value
// starts at a known, harmless level.
// Ports:
//   clk   : system clock
//   a_rst : asynchronous reset, active-high
//   s_rst : synchronous reset, active-high
//   d_i   : asynchronous input
//   q_o   : synchronized output (stage 2)
// -----------------------------------------------------------------------------
module spi_sync #(
  parameter logic P_RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic a_rst,
  input  logic s_rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Stage 1 may go metastable; stage 2 gives it a full cycle to resolve.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      meta_q <= P_RESET_VAL;
      sync_q <= P_RESET_VAL;
    end else if (s_rst) begin
      meta_q <= P_RESET_VAL;
      sync_q <= P_RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_receiver.sv
// -----------------------------------------------------------------------------
// spi_receiver
// SPI slave receive path, oversampled in the clk domain. sck, cs_n and mosi
// are synchronized, sck edges are detected in clk, and bits are shifted in
// MSB first. Completed words are presented on a valid/ready output; a word
// that completes while an unconsumed word is still held is dropped and
// flagged with a one-cycle overflow pulse.
// Parameters:
//   P_DATA_WIDTH  : bits per word
//   P_CS_POLAR    : idle level of cs_n (active level is the inverse)
//   P_SAMPLE_RISE : 1 = sample mosi on rising sck, 0 = on falling sck
// Ports:
//   clk, a_rst (async, active-high), s_rst (sync, active-high)
//   sck, cs_n, mosi          : raw SPI inputs, asynchronous to clk
//   out_data/out_valid/out_ready : received word handshake
//   overflow                 : one-cycle pulse when a completed word is dropped
//   busy                     : synchronized cs_n is active and a frame is open
//   frame_err                : (only with SPI_RX_FRAME_ERR_EN defined) one-cycle
//                              pulse when a partial word is discarded at cs_n
//                              deassertion
// -----------------------------------------------------------------------------
module spi_receiver
  import spi_pkg::*;
#(
  parameter int P_DATA_WIDTH  = SPI_DEFAULT_DATA_WIDTH,
  parameter int P_CS_POLAR    = SPI_DEFAULT_CS_POLAR,
  parameter int P_SAMPLE_RISE = 1
) (
  input  logic                    clk,
  input  logic                    a_rst,
  input  logic                    s_rst,
  input  logic                    sck,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic [P_DATA_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow,
  output logic                    busy
`ifdef SPI_RX_FRAME_ERR_EN
  ,output logic                   frame_err
`endif
);

  localparam int                CNT_W    = $clog2(P_DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(P_DATA_WIDTH - 1);
  localparam logic              CS_IDLE  = P_CS_POLAR[0];
  localparam bit                ON_RISE  = (P_SAMPLE_RISE != 0);

  logic sckSync;
  logic csSync;
  logic mosiSync;

  spi_sync #(.P_RESET_VAL(1'b0)) uSyncSck (
    .clk(clk), .a_rst(a_rst), .s_rst(s_rst), .d_i(sck), .q_o(sckSync)
  );

  spi_sync #(.P_RESET_VAL(CS_IDLE)) uSyncCs (
    .clk(clk), .a_rst(a_rst), .s_rst(s_rst), .d_i(cs_n), .q_o(csSync)
  );

  spi_sync #(.P_RESET_VAL(1'b0)) uSyncMosi (
    .clk(clk), .a_rst(a_rst), .s_rst(s_rst), .d_i(mosi), .q_o(mosiSync)
  );

  spi_state_e              state_q;
  logic                    sckDly_q;
  logic [P_DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]        bitCnt_q;
  logic [P_DATA_WIDTH-1:0] outData_q;
  logic                    outValid_q;
  logic                    overflow_q;
  logic                    busy_q;
  logic                    armed_q;
  logic [1:0]              flushCnt_q;
`ifdef SPI_RX_FRAME_ERR_EN
  logic                    frameErr_q;
`endif

  logic                    sampleEdge;
  logic                    csActive;
  logic                    lastBit;
  logic                    flushDone;
  logic [P_DATA_WIDTH-1:0] shift_d;

  // Edge detect compares synchronizer stage 2 against one more delay flop.
  // mosi has the same synchronizer latency as sck, so mosiSync is the bit
  // that was on the wire at the detected sck edge. lastBit is evaluated even
  // when cs_n drops in the same cycle so that a word finishing exactly at
  // deselect is still delivered.
  always_comb begin
    sampleEdge = ON_RISE ? (sckSync & ~sckDly_q) : (~sckSync & sckDly_q);
    csActive   = (csSync != CS_IDLE);
    flushDone  = (flushCnt_q == 2'd2);
    lastBit    = (state_q == RECV) && sampleEdge && (bitCnt_q == LAST_CNT);
    shift_d    = {shift_q[P_DATA_WIDTH-2:0], mosiSync};
  end

  // Receiver FSM with registered outputs. After any reset the synchronizers
  // hold the reset value for two cycles, which looks like "cs inactive" even
  // if cs_n is really held active; flushCnt_q waits those cycles out before
  // armed_q may be set, so a frame only starts after a genuine inactive level
  // followed by an active one.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q    <= IDLE;
      sckDly_q   <= 1'b0;
      shift_q    <= '0;
      bitCnt_q   <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      armed_q    <= 1'b0;
      flushCnt_q <= 2'd0;
`ifdef SPI_RX_FRAME_ERR_EN
      frameErr_q <= 1'b0;
`endif
    end else if (s_rst) begin
      state_q    <= IDLE;
      sckDly_q   <= 1'b0;
      shift_q    <= '0;
      bitCnt_q   <= '0;
      outData_q  <= '0;
      outValid_q <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      armed_q    <= 1'b0;
      flushCnt_q <= 2'd0;
`ifdef SPI_RX_FRAME_ERR_EN
      frameErr_q <= 1'b0;
`endif
    end else begin
      sckDly_q   <= sckSync;
      overflow_q <= 1'b0;
`ifdef SPI_RX_FRAME_ERR_EN
      frameErr_q <= 1'b0;
`endif
      if (!flushDone) begin
        flushCnt_q <= flushCnt_q + 2'd1;
      end

      // Output register: a handshake frees the slot, and a word completing
      // in the same cycle may reuse it immediately.
      if (outValid_q && out_ready) begin
        outValid_q <= 1'b0;
      end
      if (lastBit) begin
        if (!outValid_q || out_ready) begin
          outData_q  <= shift_d;
          outValid_q <= 1'b1;
        end else begin
          overflow_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (flushDone && !csActive) begin
            armed_q <= 1'b1;
          end
          if (armed_q && csActive) begin
            state_q <= RECV;
            busy_q  <= 1'b1;
          end
        end
        RECV: begin
          if (!csActive) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            shift_q  <= '0;
            bitCnt_q <= '0;
`ifdef SPI_RX_FRAME_ERR_EN
            if (!lastBit && (bitCnt_q != '0)) begin
              frameErr_q <= 1'b1;
            end
`endif
          end else if (sampleEdge) begin
            shift_q  <= shift_d;
            bitCnt_q <= lastBit ? '0 : bitCnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_data  = outData_q;
  assign out_valid = outValid_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;
`ifdef SPI_RX_FRAME_ERR_EN
  assign frame_err = frameErr_q;
`endif

endmodule

// File: tb/tb_spi_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_receiver
// Directed bench for spi_receiver. Two instances share clk, resets, sck and
// mosi: the default one (cs idle high, rising-edge sampling) and an alternate
// one (cs idle low, falling-edge sampling) with its own chip select.
// Each SPI bit lasts 8 clk cycles; inputs change and outputs are sampled on
// the falling clk edge. frame_err checks exist only with SPI_RX_FRAME_ERR_EN.
// -----------------------------------------------------------------------------
module tb_spi_receiver;

  logic       clk = 1'b0;
  logic       a_rst = 1'b0;
  logic       s_rst = 1'b0;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       csN = 1'b1;
  logic       csAlt = 1'b0;
  logic       outReady = 1'b0;
  logic       readyAlt = 1'b0;

  logic [7:0] outData;
  logic       outValid;
  logic       overflow;
  logic       busy;
  logic [7:0] outDataAlt;
  logic       outValidAlt;
  logic       overflowAlt;
  logic       busyAlt;
`ifdef SPI_RX_FRAME_ERR_EN
  logic       frameErr;
  logic       frameErrAlt;
`endif

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] hsQ[$];
  int ovfCount      = 0;
  int validCount    = 0;
  int frameErrCount = 0;

  always #5 clk = ~clk;

  spi_receiver dut (
    .clk(clk), .a_rst(a_rst), .s_rst(s_rst),
    .sck(sck), .cs_n(csN), .mosi(mosi),
    .out_data(outData), .out_valid(outValid), .out_ready(outReady),
    .overflow(overflow), .busy(busy)
`ifdef SPI_RX_FRAME_ERR_EN
    ,.frame_err(frameErr)
`endif
  );

  spi_receiver #(.P_DATA_WIDTH(8), .P_CS_POLAR(0), .P_SAMPLE_RISE(0)) dutAlt (
    .clk(clk), .a_rst(a_rst), .s_rst(s_rst),
    .sck(sck), .cs_n(csAlt), .mosi(mosi),
    .out_data(outDataAlt), .out_valid(outValidAlt), .out_ready(readyAlt),
    .overflow(overflowAlt), .busy(busyAlt)
`ifdef SPI_RX_FRAME_ERR_EN
    ,.frame_err(frameErrAlt)
`endif
  );

  // Monitors record handshakes and pulse counts on the default instance;
  // tests compare against deltas from a base taken at their start.
  always @(posedge clk) begin
    if (outValid && outReady) hsQ.push_back(outData);
    if (overflow) ovfCount++;
    if (outValid) validCount++;
`ifdef SPI_RX_FRAME_ERR_EN
    if (frameErr) frameErrCount++;
`endif
  end

  task automatic waitClk(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One bit, mode-0 style: data set up 2 clk before rise, held until 2 clk
  // after fall, so it is stable at whichever edge the instance samples.
  task automatic applyStimulus(input logic b);
    mosi = b;
    waitClk(2);
    sck = 1'b1;
    waitClk(4);
    sck = 1'b0;
    waitClk(2);
  endtask

  task automatic sendWord(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) applyStimulus(w[i]);
  endtask

  // Last bit with out_valid latency measured from the raw sampling edge.
  task automatic sendLast(input logic b, input bit useAlt, output int lat);
    lat = -1;
    mosi = b;
    waitClk(2);
    sck = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (!useAlt && lat < 0 && outValid) lat = i;
    end
    sck = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (useAlt && lat < 0 && outValidAlt) lat = i;
    end
  endtask

  task automatic test_reset;
    a_rst = 1'b1;
    waitClk(3);
    assertCount++;
    if (outValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid got %b want 0", outValid); end
    assertCount++;
    if (outData !== 8'h00) begin failCount++; $display("[TB] FAIL reset_data got %h want 00", outData); end
    assertCount++;
    if (overflow !== 1'b0) begin failCount++; $display("[TB] FAIL reset_overflow got %b want 0", overflow); end
    assertCount++;
    if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    a_rst = 1'b0;
    waitClk(6);
  endtask

  task automatic test_single_word;
    int lat;
    logic [7:0] w;
    w = 8'hA5;
    outReady = 1'b0;
    csN = 1'b0;
    waitClk(4);
    assertCount++;
    if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL single_busy got %b want 1", busy); end
    for (int i = 7; i >= 1; i--) applyStimulus(w[i]);
    sendLast(w[0], 1'b0, lat);
    assertCount++;
    if (lat < 1 || lat > 4) begin failCount++; $display("[TB] FAIL single_latency got %0d want 1..4", lat); end
    assertCount++;
    if (outData !== 8'hA5) begin failCount++; $display("[TB] FAIL single_data got %h want a5", outData); end
    assertCount++;
    if (overflow !== 1'b0) begin failCount++; $display("[TB] FAIL single_overflow got %b want 0", overflow); end
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    assertCount++;
    if (outValid !== 1'b0) begin failCount++; $display("[TB] FAIL single_valid_drop got %b want 0", outValid); end
    csN = 1'b1;
    waitClk(5);
    assertCount++;
    if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL single_busy_end got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int base;
    base = hsQ.size();
    outReady = 1'b1;
    csN = 1'b0;
    waitClk(4);
    sendWord(8'h3C);
    sendWord(8'hC3);
    waitClk(4);
    csN = 1'b1;
    waitClk(5);
    assertCount++;
    if (hsQ.size() - base != 2) begin
      failCount++; $display("[TB] FAIL b2b_count got %0d want 2", hsQ.size() - base);
    end else begin
      assertCount++;
      if (hsQ[base] !== 8'h3C) begin failCount++; $display("[TB] FAIL b2b_first got %h want 3c", hsQ[base]); end
      assertCount++;
      if (hsQ[base+1] !== 8'hC3) begin failCount++; $display("[TB] FAIL b2b_second got %h want c3", hsQ[base+1]); end
    end
  endtask

  task automatic test_overflow;
    int base;
    int ovfBase;
    outReady = 1'b0;
    ovfBase = ovfCount;
    csN = 1'b0;
    waitClk(4);
    sendWord(8'h11);
    assertCount++;
    if (outValid !== 1'b1) begin failCount++; $display("[TB] FAIL ovf_first_valid got %b want 1", outValid); end
    sendWord(8'h22);
    waitClk(4);
    assertCount++;
    if (outData !== 8'h11) begin failCount++; $display("[TB] FAIL ovf_data_kept got %h want 11", outData); end
    assertCount++;
    if (ovfCount - ovfBase != 1) begin failCount++; $display("[TB] FAIL ovf_pulses got %0d want 1", ovfCount - ovfBase); end
    csN = 1'b1;
    waitClk(5);
    base = hsQ.size();
    outReady = 1'b1;
    waitClk(6);
    outReady = 1'b0;
    assertCount++;
    if (hsQ.size() - base != 1) begin
      failCount++; $display("[TB] FAIL ovf_drain_count got %0d want 1", hsQ.size() - base);
    end else begin
      assertCount++;
      if (hsQ[base] !== 8'h11) begin failCount++; $display("[TB] FAIL ovf_drain_value got %h want 11", hsQ[base]); end
    end
  endtask

  task automatic test_abort;
    int base;
    int validBase;
    int ferrBase;
    outReady = 1'b1;
    validBase = validCount;
    ferrBase = frameErrCount;
    csN = 1'b0;
    waitClk(4);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1);
    csN = 1'b1;
    waitClk(6);
    assertCount++;
    if (validCount != validBase) begin failCount++; $display("[TB] FAIL abort_no_valid got %0d want 0", validCount - validBase); end
    assertCount++;
    if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
`ifdef SPI_RX_FRAME_ERR_EN
    assertCount++;
    if (frameErrCount - ferrBase != 1) begin failCount++; $display("[TB] FAIL abort_frame_err got %0d want 1", frameErrCount - ferrBase); end
`endif
    base = hsQ.size();
    csN = 1'b0;
    waitClk(4);
    sendWord(8'h5A);
    waitClk(4);
    csN = 1'b1;
    waitClk(5);
    assertCount++;
    if (hsQ.size() - base != 1 || hsQ[base] !== 8'h5A) begin
      failCount++; $display("[TB] FAIL abort_recover got %0d words want one 5a", hsQ.size() - base);
    end
  endtask

  task automatic test_reset_midframe;
    int base;
    logic [7:0] w;
    w = 8'h81;
    outReady = 1'b1;
    csN = 1'b0;
    waitClk(4);
    for (int i = 7; i >= 4; i--) applyStimulus(w[i]);
    a_rst = 1'b1;
    @(negedge clk);
    assertCount++;
    if (outValid !== 1'b0 || outData !== 8'h00 || overflow !== 1'b0 || busy !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midreset_outputs got v=%b d=%h o=%b b=%b want all 0", outValid, outData, overflow, busy);
    end
    csN = 1'b1;
    waitClk(2);
    a_rst = 1'b0;
    waitClk(6);
    base = hsQ.size();
    csN = 1'b0;
    waitClk(4);
    sendWord(8'h81);
    waitClk(4);
    csN = 1'b1;
    waitClk(5);
    assertCount++;
    if (hsQ.size() - base != 1 || hsQ[base] !== 8'h81) begin
      failCount++; $display("[TB] FAIL midreset_recover got %0d words want one 81", hsQ.size() - base);
    end
  endtask

  task automatic test_polarity_edge;
    int lat;
    logic [7:0] w;
    w = 8'hA5;
    readyAlt = 1'b0;
    csAlt = 1'b1;
    waitClk(4);
    assertCount++;
    if (busyAlt !== 1'b1) begin failCount++; $display("[TB] FAIL alt_busy got %b want 1", busyAlt); end
    for (int i = 7; i >= 1; i--) applyStimulus(w[i]);
    sendLast(w[0], 1'b1, lat);
    assertCount++;
    if (lat < 1 || lat > 4) begin failCount++; $display("[TB] FAIL alt_latency got %0d want 1..4", lat); end
    assertCount++;
    if (outDataAlt !== 8'hA5) begin failCount++; $display("[TB] FAIL alt_data got %h want a5", outDataAlt); end
    assertCount++;
    if (overflowAlt !== 1'b0) begin failCount++; $display("[TB] FAIL alt_overflow got %b want 0", overflowAlt); end
    assertCount++;
    if (outValid !== 1'b0) begin failCount++; $display("[TB] FAIL alt_default_quiet got %b want 0", outValid); end
    csAlt = 1'b0;
    waitClk(5);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overflow();
    test_abort();
    test_reset_midframe();
    test_polarity_edge();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
